// File: rtl/mod_pow_param.sv
// mod_pow_param: result = a^b mod m using an internal interleaved shift-add modular multiplier.
// Optional macro MOD_POW_PARALLEL_SQR_EN adds a second datapath so multiply and square share one phase.
module mod_pow_param #(
  parameter int WIDTH = 260
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, CHECK, MUL, SQR, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, m_r, base, temp, p, p_n, src, addend, base_n;
  logic [CW-1:0] cnt;
  logic phase, last, b_shift, base_we;

  // one shift-add step: 2*pv mod mv, then optionally add xv mod mv; both stay below 2*mv in WIDTH+1 bits
  function automatic logic [WIDTH-1:0] mstep(input logic [WIDTH-1:0] pv, input logic sv,
                                             input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] mv);
    logic [WIDTH:0] t, u, mm;
    mm = {1'b0, mv};
    t = {pv, 1'b0};
    t = (t >= mm) ? t - mm : t;
    u = t + (sv ? {1'b0, xv} : '0);
    return (u >= mm) ? WIDTH'(u - mm) : u[WIDTH-1:0];
  endfunction

  // reduction reuses the multiplier step with a constant addend of 1, scanning a's bits MSB first
  assign phase  = (state == REDUCE) || (state == MUL) || (state == SQR);
  assign last   = (cnt == '0);
  assign src    = (state == REDUCE) ? a_r : (state == MUL) ? temp : base;
  assign addend = (state == REDUCE) ? ONE : base;
  assign p_n    = mstep(p, src[cnt], addend, m_r);

`ifdef MOD_POW_PARALLEL_SQR_EN
  logic [WIDTH-1:0] p2, p2_n;
  assign p2_n    = mstep(p2, base[cnt], base, m_r);
  assign b_shift = last && ((state == MUL) || (state == SQR));
  assign base_we = phase && last;
  assign base_n  = (state == MUL) ? p2_n : p_n;

  // squaring partial product running alongside the multiply phase from the pre-update base
  always_ff @(posedge clk or negedge reset)
    if (!reset) p2 <= '0;
    else p2 <= (state == MUL && !last) ? p2_n : '0;
`else
  assign b_shift = last && ((state == SQR) || (state == MUL && b_r[WIDTH-1:1] == '0));
  assign base_we = last && ((state == REDUCE) || (state == SQR));
  assign base_n  = p_n;
`endif

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  // next-state logic; the final squaring is skipped once no exponent bits remain
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (m == '0) ? FIN : REDUCE;
      REDUCE:  state_n = last ? CHECK : REDUCE;
      CHECK:   state_n = (b_r == '0) ? FIN : b_r[0] ? MUL : SQR;
`ifdef MOD_POW_PARALLEL_SQR_EN
      MUL:     state_n = last ? CHECK : MUL;
`else
      MUL:     state_n = !last ? MUL : (b_r[WIDTH-1:1] == '0) ? CHECK : SQR;
`endif
      SQR:     state_n = last ? CHECK : SQR;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // operand latches, bit counter, partial product, base/temp and status outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_r <= '0; b_r <= '0; m_r <= '0; base <= '0; temp <= '0; p <= '0; cnt <= '0;
      result <= '0; done <= 1'b0; busy <= 1'b0; err <= 1'b0;
    end else begin
      a_r    <= (state == LOAD) ? a : a_r;
      m_r    <= (state == LOAD) ? m : m_r;
      b_r    <= (state == LOAD) ? b : b_shift ? b_r >> 1 : b_r;
      cnt    <= (phase && !last) ? cnt - 1'b1 : CW'(WIDTH - 1);
      p      <= (phase && !last) ? p_n : '0;
      base   <= base_we ? base_n : base;
      temp   <= !last ? temp : (state == REDUCE) ? ((m_r == ONE) ? '0 : ONE) : (state == MUL) ? p_n : temp;
      busy   <= (state == LOAD) ? 1'b1 : (state == FIN) ? 1'b0 : busy;
      err    <= (state == LOAD) ? (m == '0) : err;
      result <= (state == LOAD && m == '0) ? '0 : (state == FIN) ? (err ? '0 : temp) : result;
      done   <= (state == IDLE) ? !start : (state == FIN) ? 1'b1 : done;
    end
endmodule

// File: tb/tb_mod_pow_param.sv
// tb_mod_pow_param: vector table, random model comparison and corner sequences for mod_pow_param.
module tb_mod_pow_param;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, m8 = '0, result8;
  logic done8, busy8, err8;
  logic start2 = 1'b0;
  logic [259:0] a2 = '0, b2 = '0, m2 = '0, result2;
  logic done2, busy2, err2;
  int checks = 0, errors = 0;

  mod_pow_param #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .m(m8),
                                 .result(result8), .done(done8), .busy(busy8), .err(err8));
  mod_pow_param #(.WIDTH(260)) u260 (.clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .m(m2),
                                     .result(result2), .done(done2), .busy(busy2), .err(err2));

  typedef struct { logic [7:0] a, b, m, res; logic err; } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_pow(input int x_a, input int x_b, input int x_m);
    int r;
    if (x_m == 0) return 8'd0;
    r = 1 % x_m;
    for (int i = 0; i < x_b; i++) r = (r * (x_a % x_m)) % x_m;
    return 8'(r);
  endfunction

  function automatic int ref_lat(input int w, input logic [259:0] x_b, input logic mz);
    int top, n;
    if (mz) return 2;
    top = -1;
    n = 3 + w;
    for (int i = 0; i < w; i++) if (x_b[i]) top = i;
    for (int i = 0; i <= top; i++)
`ifdef MOD_POW_PARALLEL_SQR_EN
      n += 1 + ((x_b[i] || i != top) ? w : 0);
`else
      n += 1 + (x_b[i] ? w : 0) + ((i != top) ? w : 0);
`endif
    return n;
  endfunction

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run8(input logic [7:0] x_a, input logic [7:0] x_b, input logic [7:0] x_m,
                      input logic [7:0] e_res, input logic e_err, input string name);
    int cyc;
    a8 = x_a; b8 = x_b; m8 = x_m; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(cyc);
    chk({name, " result"}, result8, e_res);
    chk({name, " err"}, err8, e_err);
    chk({name, " latency"}, cyc, ref_lat(8, x_b, x_m == 0));
    chk({name, " busy"}, busy8, 0);
  endtask

  task automatic run260(input logic [259:0] x_a, input logic [259:0] x_b, input logic [259:0] x_m,
                        input logic [259:0] e_res, input string name);
    int cyc;
    a2 = x_a; b2 = x_b; m2 = x_m; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, " result"}, result2, e_res);
    chk({name, " err"}, err2, 0);
    chk({name, " latency"}, cyc, ref_lat(260, x_b, 1'b0));
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb, rm;
    logic [259:0] big_m;
    vecs[0]  = '{8'd3,   8'd13,  8'd7,   8'd3,  1'b0};
    vecs[1]  = '{8'd200, 8'd3,   8'd7,   8'd1,  1'b0};
    vecs[2]  = '{8'd6,   8'd0,   8'd5,   8'd1,  1'b0};
    vecs[3]  = '{8'd9,   8'd4,   8'd1,   8'd0,  1'b0};
    vecs[4]  = '{8'd5,   8'd3,   8'd0,   8'd0,  1'b1};
    vecs[5]  = '{8'd2,   8'd7,   8'd100, 8'd28, 1'b0};
    vecs[6]  = '{8'd254, 8'd2,   8'd255, 8'd1,  1'b0};
    vecs[7]  = '{8'd0,   8'd5,   8'd13,  8'd0,  1'b0};
    vecs[8]  = '{8'd255, 8'd255, 8'd255, 8'd0,  1'b0};
    vecs[9]  = '{8'd10,  8'd1,   8'd3,   8'd1,  1'b0};
    vecs[10] = '{8'd7,   8'd0,   8'd1,   8'd0,  1'b0};
    vecs[11] = '{8'd2,   8'd8,   8'd251, 8'd5,  1'b0};
    vecs[12] = '{8'd255, 8'd255, 8'd254, 8'd1,  1'b0};
    #1;
    chk("reset result", result8, 0);
    chk("reset done", done8, 0);
    chk("reset busy", busy8, 0);
    chk("reset err", err8, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("idle done", done8, 1);

    for (int i = 0; i < 13; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].res, vecs[i].err, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      run8(ra, rb, rm, ref_pow(ra, rb, rm), rm == 0, $sformatf("rand%0d", i));
    end

    a8 = 8'd3; b8 = 8'd13; m8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("repulse busy", busy8, 1);
    a8 = 8'd2; b8 = 8'd7; m8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(cyc);
    chk("repulse result", result8, 3);
    chk("repulse latency", cyc + 6, ref_lat(8, 8'd13, 1'b0));

    a8 = 8'd3; b8 = 8'd13; m8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("midsqr busy", busy8, 1);
    chk("midsqr result held", result8, 3);
    #2 reset = 1'b0;
    #1;
    chk("async reset result", result8, 0);
    chk("async reset busy", busy8, 0);
    chk("async reset done", done8, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run8(8'd2, 8'd7, 8'd100, 8'd28, 1'b0, "after reset");

    big_m = (260'd1 << 259) + 260'd7;
    run260(big_m - 260'd1, 260'd2, big_m, 260'd1, "w260 b2");
    run260(big_m - 260'd1, 260'd3, big_m, big_m - 260'd1, "w260 b3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
